// File: rtl/xnor_stream_checker.sv
// Serial bit-pair equality checker: counts XNOR mismatches over a FRAME_LEN-pair
// frame and reports a registered pass/fail verdict with a one-cycle done pulse.
module xnor_stream_checker #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t           state, state_nxt;
    logic             busy_nxt, done_nxt;
    logic             take, last, eq;
    logic [CNT_W-1:0] err_nxt;

    assign take    = (state == RUN) && in_valid;
    assign last    = take && (bit_idx == LAST);
    assign eq      = ~(a ^ b);
    assign err_nxt = (!eq && err_count != CMAX) ? err_count + CNT_W'(1) : err_count;

    // State register; busy/done are registered from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    // Verdict is settled on the edge that consumes the last pair, so it is
    // already valid in the DONE cycle and then held through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            bit_idx   <= '0;
            match     <= 1'b0;
        end else if (state == IDLE && start) begin
            err_count <= '0;
            bit_idx   <= '0;
            match     <= 1'b0;
        end else if (take) begin
            err_count <= err_nxt;
            match     <= last && (err_nxt == '0);
            if (!last)
                bit_idx <= bit_idx + IDX_W'(1);
        end
    end

endmodule
